adc_frame_buffer: RTL



---
 rtl/adc_frame_buffer_if.sv | 37 +++
 rtl/adc_frame_buffer.sv | 111 +++++++++++
 2 files changed

// File: rtl/adc_frame_buffer_if.sv
// rtl/adc_frame_buffer_if.sv - sample-in / frame-read bus of the ADC frame buffer
//
// Purpose: groups the ADC-side capture signals and the FFT-side frame read
//          handshake into one bundle.
// Signals:
//   data_in     ADC conversion word (16 bits, low SAMPLE_BITS used)
//   dv          ADC data-valid; each rising edge is one sample
//   rd_addr     natural-order read address into the read bank
//   rd_data     registered signed sample at rd_addr
//   frame_ready a complete frame is held in the read bank
//   frame_ack   consumer releases the read bank
//   overrun     sticky: a completed frame was dropped
// Modports: master = ADC source / FFT consumer side, slave = frame buffer.
interface adc_frame_buffer_if #(
   parameter int N_POINTS    = 64,
   parameter int SAMPLE_BITS = 12
);
   localparam int AW = $clog2(N_POINTS);

   logic [15:0]            data_in;
   logic                   dv;
   logic [AW-1:0]          rd_addr;
   logic [SAMPLE_BITS-1:0] rd_data;
   logic                   frame_ready;
   logic                   frame_ack;
   logic                   overrun;

   modport master (
      output data_in, dv, rd_addr, frame_ack,
      input  rd_data, frame_ready, overrun
   );

   modport slave (
      input  data_in, dv, rd_addr, frame_ack,
      output rd_data, frame_ready, overrun
   );
endinterface

// File: rtl/adc_frame_buffer.sv
// rtl/adc_frame_buffer.sv - ping-pong frame buffer with bit-reversed write order
//
// Purpose: captures one sample per DV rising edge, converts offset-binary to
//          two's complement, and writes it to the write bank at the
//          bit-reversed frame index. Completed frames are handed to the
//          consumer through frame_ready / frame_ack; a frame completing while
//          the read bank is still held is dropped and flags overrun.
// Ports:
//   clock_i    system clock, rising edge
//   reset_n_i  synchronous active-low reset
//   fb_io      adc_frame_buffer_if slave (data_in, dv, rd_addr, rd_data,
//              frame_ready, frame_ack, overrun)
module adc_frame_buffer #(
   parameter int N_POINTS    = 64,
   parameter int SAMPLE_BITS = 12,
   parameter int MIDSCALE    = 2048
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   adc_frame_buffer_if.slave    fb_io
);
   localparam int AW = $clog2(N_POINTS);
   localparam logic [SAMPLE_BITS-1:0] MID   = SAMPLE_BITS'(MIDSCALE);
   localparam logic [AW-1:0]          LAST  = AW'(N_POINTS - 1);

   logic                   dv_q;
   logic [AW-1:0]          wcnt_q, wcnt_d;
   logic                   wbank_q, wbank_d;
   logic                   held_q, held_d;
   logic                   overrun_q, overrun_d;
   logic [SAMPLE_BITS-1:0] rd_data_q;

   // Bank select is the MSB of the RAM index: {bank, address}.
   logic [SAMPLE_BITS-1:0] mem [2*N_POINTS];

   logic                   sample_evt;
   logic                   held_after_ack;
   logic [AW-1:0]          wr_addr;
   logic [SAMPLE_BITS-1:0] sample;

   // Upper data_in bits carry no sample information.
   logic unused_data_bits;
   assign unused_data_bits = ^fb_io.data_in;

   assign sample_evt     = fb_io.dv & ~dv_q;
   assign held_after_ack = held_q & ~fb_io.frame_ack;
   // Modulo subtraction turns offset-binary into two's complement.
   assign sample         = fb_io.data_in[SAMPLE_BITS-1:0] - MID;

   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < AW; i++) begin
         wr_addr[AW-1-i] = wcnt_q[i];
      end
   end

   // Ack is resolved before completion, so a coincident ack lets the frame swap in.
   always_comb begin
      wcnt_d    = wcnt_q;
      wbank_d   = wbank_q;
      held_d    = held_after_ack;
      overrun_d = overrun_q;
      if (sample_evt) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == LAST) begin
            if (held_after_ack) begin
               overrun_d = 1'b1;
            end else begin
               wbank_d = ~wbank_q;
               held_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         // DV history resets high so a level already present is not a sample.
         dv_q      <= 1'b1;
         wcnt_q    <= '0;
         wbank_q   <= 1'b0;
         held_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         dv_q      <= fb_io.dv;
         wcnt_q    <= wcnt_d;
         wbank_q   <= wbank_d;
         held_q    <= held_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_n_i && sample_evt) begin
         mem[{wbank_q, wr_addr}] <= sample;
      end
   end

   // Uses the pre-edge bank select, so a read at the swap edge sees the old frame.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[{~wbank_q, fb_io.rd_addr}];
      end
   end

   assign fb_io.rd_data     = rd_data_q;
   assign fb_io.frame_ready = held_q;
   assign fb_io.overrun     = overrun_q;
endmodule
